// File: rtl/dvi_pattern_gen.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | dvi_pattern_gen: DVI test-pattern source (gradient/bars/checker/solid)     |
// | with a zero-latency rdy handshake. Revision: 1.0                          |
// +---------------------------------------------------------------------------+
module dvi_pattern_gen #(
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int H_REPEAT   = 2,
   parameter int CHECK_LOG2 = 5
) (
   input  logic        clk_pix,
   input  logic        rst_n_pix,
   input  logic        en,
   input  logic [1:0]  mode,
   input  logic [23:0] solid_rgb,
   input  logic        rgb_rdy,
   output logic [7:0]  r,
   output logic [7:0]  g,
   output logic [7:0]  b,
   output logic        sof,
   output logic        eol,
   output logic [7:0]  frame_ctr
);

   localparam int XW = $clog2(H_ACTIVE);
   localparam int YW = $clog2(V_ACTIVE);
   localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - H_REPEAT);
   localparam logic [XW-1:0] X_STEP = XW'(H_REPEAT);
   localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
   localparam logic [XW-1:0] BAR_W  = XW'(H_ACTIVE / 8);

   logic [XW-1:0] x_pos_q, x_pos_d;
   logic [YW-1:0] y_q, y_d;
   logic [7:0]    frame_q, frame_d;
   logic [1:0]    mode_q, mode_d;
   logic [23:0]   rgb_q, rgb_d;

   function automatic logic [23:0] pattern(
      input logic [XW-1:0] x,
      input logic [YW-1:0] y,
      input logic [7:0]    f,
      input logic [1:0]    m,
      input logic [23:0]   solid
   );
      logic [7:0] rr;
      logic [7:0] gg;
      logic [7:0] bb;
      logic [2:0] bar;
      logic       white;
      rr    = 8'h00;
      gg    = 8'h00;
      bb    = 8'h00;
      bar   = 3'd0;
      white = 1'b0;
      case (m)
         2'd0: begin
            rr = 8'(x) + f;
            gg = 8'(y) + {f[6:0], 1'b0};
            bb = f;
         end
         2'd1: begin
            // bar index bits map directly onto the inverted colour channels
            bar = 3'(x / BAR_W);
            rr  = {8{~bar[1]}};
            gg  = {8{~bar[2]}};
            bb  = {8{~bar[0]}};
         end
         2'd2: begin
            white = x[CHECK_LOG2] ^ y[CHECK_LOG2] ^ f[5];
            rr    = {8{white}};
            gg    = {8{white}};
            bb    = {8{white}};
         end
         default: begin
            rr = solid[23:16];
            gg = solid[15:8];
            bb = solid[7:0];
         end
      endcase
      return {rr, gg, bb};
   endfunction

   always_comb begin
      x_pos_d = x_pos_q;
      y_d     = y_q;
      frame_d = frame_q;
      mode_d  = mode_q;
      if (!rst_n_pix) begin
         x_pos_d = '0;
         y_d     = '0;
         frame_d = '0;
         mode_d  = mode;
      end else if (!en) begin
         x_pos_d = '0;
         y_d     = '0;
         mode_d  = mode;
      end else if (rgb_rdy) begin
         if (x_pos_q == X_LAST) begin
            x_pos_d = '0;
            if (y_q == Y_LAST) begin
               y_d     = '0;
               frame_d = frame_q + 8'd1;
               mode_d  = mode;
            end else begin
               y_d = y_q + YW'(1);
            end
         end else begin
            x_pos_d = x_pos_q + X_STEP;
         end
      end
      // Colour is computed from the next counters so the registered pixel
      // always matches the counters it is presented with.
      rgb_d = pattern(x_pos_d, y_d, frame_d, mode_d, solid_rgb);
   end

   always_ff @(posedge clk_pix) begin
      x_pos_q <= x_pos_d;
      y_q     <= y_d;
      frame_q <= frame_d;
      mode_q  <= mode_d;
      rgb_q   <= rgb_d;
   end

   assign r         = rgb_q[23:16];
   assign g         = rgb_q[15:8];
   assign b         = rgb_q[7:0];
   assign sof       = (x_pos_q == '0) && (y_q == '0);
   assign eol       = (x_pos_q == X_LAST);
   assign frame_ctr = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_dvi_pattern_gen.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_dvi_pattern_gen: randomized bench against a pixel-index frame model.   |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_dvi_pattern_gen;

   localparam int H   = 32;
   localparam int V   = 8;
   localparam int R   = 2;
   localparam int C   = 2;
   localparam int LPL = H / R;
   localparam int TOT = LPL * V;

   logic        clk_pix = 1'b0;
   logic        rst_n_pix;
   logic        en;
   logic [1:0]  mode;
   logic [23:0] solid_rgb;
   logic        rgb_rdy;
   logic [7:0]  r, g, b;
   logic        sof, eol;
   logic [7:0]  frame_ctr;

   always #5 clk_pix = ~clk_pix;

   dvi_pattern_gen #(
      .H_ACTIVE(H), .V_ACTIVE(V), .H_REPEAT(R), .CHECK_LOG2(C)
   ) u_dut (
      .clk_pix(clk_pix), .rst_n_pix(rst_n_pix), .en(en), .mode(mode),
      .solid_rgb(solid_rgb), .rgb_rdy(rgb_rdy), .r(r), .g(g), .b(b),
      .sof(sof), .eol(eol), .frame_ctr(frame_ctr)
   );

   int checks = 0;
   int errors = 0;

   // model: position is a pixel index within the frame
   int          p = 0;
   int          frame = 0;
   int          mdl_mode = 0;
   logic [23:0] solid_s = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [23:0] bar_colour(input int bar);
      case (bar)
         0: return 24'hFFFFFF;
         1: return 24'hFFFF00;
         2: return 24'h00FFFF;
         3: return 24'h00FF00;
         4: return 24'hFF00FF;
         5: return 24'hFF0000;
         6: return 24'h0000FF;
         default: return 24'h000000;
      endcase
   endfunction

   function automatic logic [23:0] exp_rgb();
      int x, y;
      x = (p % LPL) * R;
      y = p / LPL;
      case (mdl_mode)
         0: return {8'((x + frame) % 256), 8'((y + 2 * frame) % 256), 8'(frame % 256)};
         1: return bar_colour(x / (H / 8));
         2: return ((((x >> C) ^ (y >> C) ^ (frame >> 5)) & 1) == 1) ? 24'hFFFFFF : 24'h000000;
         default: return solid_s;
      endcase
   endfunction

   task automatic step();
      @(posedge clk_pix);
      solid_s = solid_rgb;
      if (!rst_n_pix) begin
         p = 0; frame = 0; mdl_mode = int'(mode);
      end else if (!en) begin
         p = 0; mdl_mode = int'(mode);
      end else if (rgb_rdy) begin
         p++;
         if (p == TOT) begin
            p = 0;
            frame = (frame + 1) % 256;
            mdl_mode = int'(mode);
         end
      end
      @(negedge clk_pix);
      check("rgb", 32'({r, g, b}), 32'(exp_rgb()));
      check("sof", 32'(sof), 32'(p == 0));
      check("eol", 32'(eol), 32'((p % LPL) == LPL - 1));
      check("frame_ctr", 32'(frame_ctr), 32'(frame));
   endtask

   initial begin
      rst_n_pix = 1'b0;
      en        = 1'b0;
      rgb_rdy   = 1'b0;
      mode      = 2'd0;
      solid_rgb = 24'h123456;
      repeat (3) step();
      rst_n_pix = 1'b1;

      // random handshake, mode/solid changes, occasional en drops and resets
      for (int i = 0; i < 12000; i++) begin
         en        = ($urandom_range(0, 199) != 0);
         rgb_rdy   = ($urandom_range(0, 9) < 7);
         rst_n_pix = ($urandom_range(0, 1499) != 0);
         if ($urandom_range(0, 99) == 0) mode = 2'($urandom);
         if ($urandom_range(0, 49) == 0) solid_rgb = 24'($urandom);
         step();
      end

      // continuous streaming past a frame counter wrap
      rst_n_pix = 1'b1;
      en        = 1'b1;
      rgb_rdy   = 1'b1;
      for (int i = 0; i < TOT * 258; i++) begin
         if ((i % 97) == 0) mode = 2'($urandom);
         if ((i % 53) == 0) solid_rgb = 24'($urandom);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
